// File: rtl/synverll_sdiv_arb_pkg.sv
// Shared constants and tag type for the signed-divide arbiter slice.
// Supports the optional SDIV_ARB_TAG_CHECK_EN build in the top and interface.
package synverll_sdiv_arb_pkg;

  localparam int SDIV_LATENCY = 34;
  localparam int SDIV_W       = 32;
  localparam int SDIV_NUM_REQ = 4;

  // Tag id is sized for the 16-requester maximum so one struct serves every build.
  localparam int SDIV_TAG_IDW = 4;

  typedef struct packed {
    logic                    valid;
    logic [SDIV_TAG_IDW-1:0] id;
  } tag_t;

  // Single-step modulo for values known to be below 2*n.
  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

endpackage

// File: rtl/synverll_sdiv_arb_if.sv
// Requester and divider-side signals of the divide arbiter.
// SDIV_ARB_TAG_CHECK_EN adds the sticky tag_err output.
interface synverll_sdiv_arb_if
  import synverll_sdiv_arb_pkg::*;
#(
  parameter int NUM_REQ = SDIV_NUM_REQ
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             ready;
  logic [NUM_REQ-1:0]             done;
  logic [NUM_REQ-1:0][SDIV_W-1:0] args_0;
  logic [NUM_REQ-1:0][SDIV_W-1:0] args_1;
  logic [SDIV_W-1:0]              result;
  logic                           busy;
  logic                           div_req;
  logic [SDIV_W-1:0]              div_args_0;
  logic [SDIV_W-1:0]              div_args_1;
  logic                           div_done;
  logic [SDIV_W-1:0]              div_result;
`ifdef SDIV_ARB_TAG_CHECK_EN
  logic                           tag_err;

  modport slave (
    input  req, args_0, args_1, div_done, div_result,
    output ready, done, result, busy, div_req, div_args_0, div_args_1, tag_err
  );
  modport master (
    output req, args_0, args_1, div_done, div_result,
    input  ready, done, result, busy, div_req, div_args_0, div_args_1, tag_err
  );
`else
  modport slave (
    input  req, args_0, args_1, div_done, div_result,
    output ready, done, result, busy, div_req, div_args_0, div_args_1
  );
  modport master (
    output req, args_0, args_1, div_done, div_result,
    input  ready, done, result, busy, div_req, div_args_0, div_args_1
  );
`endif

endinterface

// File: rtl/synverll_sdiv_arb_rr.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping at NUM_REQ.
module synverll_sdiv_arb_rr
  import synverll_sdiv_arb_pkg::*;
#(
  parameter int NUM_REQ = SDIV_NUM_REQ,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDW'(wrap_idx(int'(ptr) + off, NUM_REQ));
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        winner      = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synverll_sdiv_arb.sv
// Round-robin arbiter sharing one pipelined 32x32 signed divider among NUM_REQ requesters.
// Optional SDIV_ARB_TAG_CHECK_EN: sticky tag_err when div_done disagrees with the tag pipe.
module synverll_sdiv_arb
  import synverll_sdiv_arb_pkg::*;
#(
  parameter int NUM_REQ = SDIV_NUM_REQ,
  parameter int LATENCY = SDIV_LATENCY
) (
  input  logic                system_clock,
  input  logic                system_reset,
  synverll_sdiv_arb_if.slave  bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic [SDIV_W-1:0]  mux_a0;
  logic [SDIV_W-1:0]  mux_a1;
  logic [NUM_REQ-1:0] done_w;
  logic               busy_w;
  tag_t               tag_pipe [LATENCY];
  tag_t               last;

  synverll_sdiv_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  // One-hot AND-OR mux; zero operands when nothing is granted.
  always_comb begin
    mux_a0 = '0;
    mux_a1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mux_a0 |= bus.args_0[i] & {SDIV_W{grant[i]}};
      mux_a1 |= bus.args_1[i] & {SDIV_W{grant[i]}};
    end
  end

  always_ff @(posedge system_clock) begin
    if (system_reset)
      ptr <= '0;
    else if (any)
      ptr <= IDW'(wrap_idx(int'(winner) + 1, NUM_REQ));
  end

  // Ownership rides alongside the divider; the last stage lines up with div_done.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      for (int s = 0; s < LATENCY; s++)
        tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: any, id: SDIV_TAG_IDW'(winner)};
      for (int s = 1; s < LATENCY; s++)
        tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign last = tag_pipe[LATENCY-1];

  always_comb begin
    done_w = NUM_REQ'(last.valid) << last.id;
    busy_w = 1'b0;
    for (int s = 0; s < LATENCY; s++)
      busy_w |= tag_pipe[s].valid;
  end

  assign bus.ready      = grant;
  assign bus.div_req    = any;
  assign bus.div_args_0 = mux_a0;
  assign bus.div_args_1 = mux_a1;
  assign bus.done       = done_w;
  assign bus.result     = bus.div_result;
  assign bus.busy       = busy_w;

`ifdef SDIV_ARB_TAG_CHECK_EN
  logic tag_err_q;

  always_ff @(posedge system_clock) begin
    if (system_reset)
      tag_err_q <= 1'b0;
    else if (bus.div_done != last.valid)
      tag_err_q <= 1'b1;
  end

  assign bus.tag_err = tag_err_q;
`else
  // Completion is taken from the tag pipe alone in this build.
  logic unused_div_done;
  assign unused_div_done = bus.div_done;
`endif

endmodule

// File: tb/tb_synverll_sdiv_arb.sv
// Directed bench for synverll_sdiv_arb with a behavioural pipelined divider.
module tb_synverll_sdiv_arb;
  import synverll_sdiv_arb_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = SDIV_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inj = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  synverll_sdiv_arb_if #(.NUM_REQ(NR)) bus ();

  synverll_sdiv_arb #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .system_clock (clk),
    .system_reset (rst),
    .bus          (bus)
  );

  // Pipelined divider model sharing the arbiter reset.
  logic [LAT-1:0] mv;
  logic [31:0]    mq [LAT];

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mv <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], bus.div_req};
      mq[0] <= (bus.div_req && bus.div_args_1 != 0) ?
               32'($signed(bus.div_args_0) / $signed(bus.div_args_1)) : 32'hFFFF_FFFF;
      for (int s = 1; s < LAT; s++) mq[s] <= mq[s-1];
    end
  end

  assign bus.div_done   = mv[LAT-1] | inj;
  assign bus.div_result = mq[LAT-1];

  // Completion log
  int          log_id[$];
  int          log_cyc[$];
  logic [31:0] log_res[$];

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    if ($onehot(v))
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done != '0) begin
      log_id.push_back(oh_idx(bus.done));
      log_cyc.push_back(cyc);
      log_res.push_back(bus.result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
    log_res.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    settle();
    checks++; if (bus.ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b want=0000", bus.ready); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b want=0000", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.div_req !== 1'b0) begin errors++; $display("FAIL reset_div_req got=%b want=0", bus.div_req); end
    checks++; if (bus.div_args_0 !== 32'd0) begin errors++; $display("FAIL reset_div_args_0 got=%h want=0", bus.div_args_0); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int bad_busy, bad_done;
    bad_busy = 0;
    bad_done = 0;
    clear_log();
    bus.req = 4'b0100;
    bus.args_0[2] = 100;
    bus.args_1[2] = -7;
    settle();
    checks++; if (bus.ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b want=0100", bus.ready); end
    checks++; if (bus.div_req !== 1'b1) begin errors++; $display("FAIL single_div_req got=%b want=1", bus.div_req); end
    checks++; if (bus.div_args_0 !== 32'd100) begin errors++; $display("FAIL single_args_0 got=%h want=00000064", bus.div_args_0); end
    checks++; if (bus.div_args_1 !== 32'hFFFF_FFF9) begin errors++; $display("FAIL single_args_1 got=%h want=fffffff9", bus.div_args_1); end
    tick();
    bus.req = '0;
    for (int k = 1; k <= LAT; k++) begin
      settle();
      if (bus.busy !== 1'b1) bad_busy++;
      if (k < LAT && bus.done !== 4'b0000) bad_done++;
      if (k == LAT) begin
        checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL single_done got=%b want=0100", bus.done); end
        checks++; if (bus.result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL single_result got=%h want=fffffff2", bus.result); end
      end
      tick();
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL single_busy_window low_cycles=%0d want=0", bad_busy); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL single_early_done cycles=%0d want=0", bad_done); end
    settle();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL single_done_after got=%b want=0000", bus.done); end
    tick();
  endtask

  task automatic test_all_held();
    int a0 [4] = '{-100, 77, 2147483647, -2147483647 - 1};
    int a1 [4] = '{3, -5, 2, 7};
    int ex [4] = '{-33, -15, 1073741823, -306783378};
    int iss [8];
    logic [3:0] want;
    do_reset();
    clear_log();
    for (int i = 0; i < NR; i++) begin
      bus.args_0[i] = a0[i];
      bus.args_1[i] = a1[i];
    end
    bus.req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      settle();
      want = 4'b0001 << (c % 4);
      iss[c] = cyc;
      checks++; if (bus.ready !== want) begin errors++; $display("FAIL held_grant%0d got=%b want=%b", c, bus.ready, want); end
      tick();
    end
    bus.req = '0;
    repeat (LAT + 2) tick();
    checks++; if (log_id.size() != 8) begin errors++; $display("FAIL held_done_count got=%0d want=8", log_id.size()); end
    for (int c = 0; c < 8 && c < log_id.size(); c++) begin
      checks++;
      if (log_id[c] != c % 4 || log_cyc[c] != iss[c] + LAT || log_res[c] !== 32'(ex[c % 4])) begin
        errors++;
        $display("FAIL held_done%0d got id=%0d cyc=%0d res=%h want id=%0d cyc=%0d res=%h",
                 c, log_id[c], log_cyc[c], log_res[c], c % 4, iss[c] + LAT, 32'(ex[c % 4]));
      end
    end
  endtask

  task automatic test_sparse();
    clear_log();
    bus.req = 4'b0100;
    settle();
    checks++; if (bus.ready !== 4'b0100) begin errors++; $display("FAIL sparse_setup got=%b want=0100", bus.ready); end
    tick();
    bus.req = 4'b0101;
    settle();
    checks++; if (bus.ready !== 4'b0001) begin errors++; $display("FAIL sparse_wrap got=%b want=0001", bus.ready); end
    tick();
    settle();
    checks++; if (bus.ready !== 4'b0100) begin errors++; $display("FAIL sparse_next got=%b want=0100", bus.ready); end
    tick();
    settle();
    checks++; if (bus.ready !== 4'b0001) begin errors++; $display("FAIL sparse_again got=%b want=0001", bus.ready); end
    tick();
    bus.req = '0;
    repeat (LAT + 2) tick();
    checks++;
    if (log_id.size() != 4 || log_id[0] != 2 || log_id[1] != 0 || log_id[2] != 2 || log_id[3] != 0) begin
      errors++;
      $display("FAIL sparse_done_order got count=%0d want ids 2,0,2,0", log_id.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0 [10] = '{50, -50, 7, -7, 123456, -123456, 0, 1, 2147483647, -9};
    int a1 [10] = '{7, 7, -2, -2, 1000, 1000, 5, 1, -1, 4};
    int ex [10] = '{7, -7, -3, 3, 123, -123, 0, 1, -2147483647, -2};
    int iss [10];
    int bad_ready;
    bad_ready = 0;
    clear_log();
    bus.req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      bus.args_0[1] = a0[k];
      bus.args_1[1] = a1[k];
      settle();
      iss[k] = cyc;
      if (bus.ready !== 4'b0010) bad_ready++;
      tick();
    end
    bus.req = '0;
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL b2b_ready missed=%0d want=0", bad_ready); end
    repeat (LAT + 2) tick();
    checks++; if (log_id.size() != 10) begin errors++; $display("FAIL b2b_count got=%0d want=10", log_id.size()); end
    for (int k = 0; k < 10 && k < log_id.size(); k++) begin
      checks++;
      if (log_id[k] != 1 || log_cyc[k] != iss[k] + LAT || log_res[k] !== 32'(ex[k])) begin
        errors++;
        $display("FAIL b2b_done%0d got id=%0d cyc=%0d res=%h want id=1 cyc=%0d res=%h",
                 k, log_id[k], log_cyc[k], log_res[k], iss[k] + LAT, 32'(ex[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    bus.args_0[0] = 40;
    bus.args_1[0] = 8;
    bus.req = 4'b0010;
    repeat (5) tick();
    bus.req = '0;
    repeat (14) tick();
    settle();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", bus.busy); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1001;
    settle();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after got=%b want=0", bus.busy); end
    checks++; if (bus.ready !== 4'b0001) begin errors++; $display("FAIL midrst_next_grant got=%b want=0001", bus.ready); end
    tick();
    bus.req = '0;
    repeat (LAT + 2) tick();
    checks++;
    if (log_id.size() != 1 || log_id[0] != 0 || log_res[0] !== 32'd5) begin
      errors++;
      $display("FAIL midrst_done_log got count=%0d want one done for requester 0 result 5", log_id.size());
    end
  endtask

`ifdef SDIV_ARB_TAG_CHECK_EN
  task automatic test_tag_err();
    do_reset();
    settle();
    checks++; if (bus.tag_err !== 1'b0) begin errors++; $display("FAIL tagerr_reset got=%b want=0", bus.tag_err); end
    tick();
    bus.req = 4'b1000;
    bus.args_0[3] = -100;
    bus.args_1[3] = 3;
    settle();
    tick();
    bus.req = '0;
    repeat (LAT - 2) tick();
    inj = 1'b1;
    settle();
    checks++; if (bus.tag_err !== 1'b0) begin errors++; $display("FAIL tagerr_before got=%b want=0", bus.tag_err); end
    tick();
    inj = 1'b0;
    settle();
    checks++; if (bus.tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_set got=%b want=1", bus.tag_err); end
    checks++; if (bus.done !== 4'b1000) begin errors++; $display("FAIL tagerr_done got=%b want=1000", bus.done); end
    repeat (5) tick();
    settle();
    checks++; if (bus.tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_sticky got=%b want=1", bus.tag_err); end
    rst = 1'b1;
    tick();
    tick();
    settle();
    checks++; if (bus.tag_err !== 1'b0) begin errors++; $display("FAIL tagerr_clear got=%b want=0", bus.tag_err); end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    bus.req    = '0;
    bus.args_0 = '0;
    bus.args_1 = '0;
    test_reset();
    test_single();
    test_all_held();
    test_sparse();
    test_back_to_back();
    test_reset_mid();
`ifdef SDIV_ARB_TAG_CHECK_EN
    test_tag_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
